// File: rtl/uart_fifo_pkg.sv
// Shared defaults and helpers for the UART buffering FIFO: pointer wrap at an
// arbitrary depth and the occupancy-counter width.
package uart_fifo_pkg;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_DEPTH     = 16;
    localparam int DEF_AF_THRESH = 14;
    localparam int DEF_AE_THRESH = 2;

    // Increment with an explicit wrap at depth-1, so depth need not be a power of 2.
    function automatic int unsigned ptr_wrap_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

    // Occupancy spans 0..depth inclusive, hence depth+1 distinct values.
    function automatic int level_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: DEPTH x DATA_W array with a synchronous write port and an
// asynchronous read port, so the top can choose registered or fall-through reads.
module fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [PTR_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [PTR_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Contents are deliberately not reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_sync_fifo.sv
// Single-clock UART data FIFO with arbitrary depth, occupancy and threshold flags,
// sticky overflow/underflow, synchronous flush and optional first-word-fall-through.
module uart_sync_fifo
    import uart_fifo_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AF_THRESH = DEF_AF_THRESH,
    parameter int AE_THRESH = DEF_AE_THRESH,
    parameter int FWFT      = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          wr_en,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic                          rd_en,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          rd_valid,
    output logic                          empty,
    output logic                          full,
    output logic                          almost_empty,
    output logic                          almost_full,
    output logic [level_width(DEPTH)-1:0] level,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = level_width(DEPTH);

    if (DATA_W < 1) begin : g_bad_data_w
        $error("uart_sync_fifo: DATA_W must be >= 1");
    end
    if (DEPTH < 2) begin : g_bad_depth
        $error("uart_sync_fifo: DEPTH must be >= 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("uart_sync_fifo: AF_THRESH must lie in 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $error("uart_sync_fifo: AE_THRESH must lie in 0..DEPTH-1");
    end

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              empty_w, full_w;
    logic              wr_acc, rd_acc;
    logic [DATA_W-1:0] mem_rdata;

    // Flags decode only the registered level, so they never glitch on input changes.
    assign empty_w      = (level_q == '0);
    assign full_w       = (level_q == LVL_W'(DEPTH));
    assign empty        = empty_w;
    assign full         = full_w;
    assign almost_empty = (level_q <= LVL_W'(AE_THRESH));
    assign almost_full  = (level_q >= LVL_W'(AF_THRESH));
    assign level        = level_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    assign wr_acc = wr_en & ~full_w  & ~flush;
    assign rd_acc = rd_en & ~empty_w & ~flush;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = PTR_W'(ptr_wrap_inc(32'(wr_ptr_q), 32'(DEPTH)));
            end
            if (rd_acc) begin
                rd_ptr_d = PTR_W'(ptr_wrap_inc(32'(rd_ptr_q), 32'(DEPTH)));
            end
            if (wr_acc && !rd_acc) begin
                level_d = level_q + LVL_W'(1);
            end else if (rd_acc && !wr_acc) begin
                level_d = level_q - LVL_W'(1);
            end
            overflow_d  = overflow_q  | (wr_en & full_w);
            underflow_d = underflow_q | (rd_en & empty_w);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr_q),
        .wdata (wr_data),
        .raddr (rd_ptr_q),
        .rdata (mem_rdata)
    );

    if (FWFT != 0) begin : g_fwft
        assign rd_data  = mem_rdata;
        assign rd_valid = ~empty_w;
    end else begin : g_reg_read
        logic [DATA_W-1:0] rd_data_q;
        logic              rd_valid_q;

        // rd_data keeps the last popped word (also across flush); rd_valid is a 1-cycle pulse.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= rd_acc;
                if (rd_acc) begin
                    rd_data_q <= mem_rdata;
                end
            end
        end

        assign rd_data  = rd_data_q;
        assign rd_valid = rd_valid_q;
    end

endmodule

// File: tb/tb_uart_sync_fifo.sv
// Randomised scoreboard bench for uart_sync_fifo: a registered-read and a
// fall-through instance share stimulus and are checked against a queue model.
module tb_uart_sync_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 12;
    localparam int AF    = 10;
    localparam int AE    = 2;
    localparam int LW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en = 1'b0;

    logic [DW-1:0] rd_data, f_rd_data;
    logic          rd_valid, f_rd_valid;
    logic          empty, full, almost_empty, almost_full, overflow, underflow;
    logic          f_empty, f_full, f_almost_empty, f_almost_full, f_overflow, f_underflow;
    logic [LW-1:0] level, f_level;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Reference model: plain queue of stored words plus sticky flags.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] m_rd = '0;
    bit            m_valid = 1'b0;
    bit            m_ovf = 1'b0;
    bit            m_udf = 1'b0;

    always #5 clk = ~clk;

    uart_sync_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)) dut (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty), .full(full),
        .almost_empty(almost_empty), .almost_full(almost_full), .level(level),
        .overflow(overflow), .underflow(underflow)
    );

    uart_sync_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)) dut_fwft (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(f_rd_data), .rd_valid(f_rd_valid), .empty(f_empty), .full(f_full),
        .almost_empty(f_almost_empty), .almost_full(f_almost_full), .level(f_level),
        .overflow(f_overflow), .underflow(f_underflow)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        m_rd    = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
    endtask

    // One clock of stimulus; the model applies the rules to the pre-edge state.
    task automatic step(input bit w, input logic [DW-1:0] wd, input bit r, input bit f);
        wr_en   = w;
        wr_data = wd;
        rd_en   = r;
        flush   = f;
        @(posedge clk);
        m_valid = 1'b0;
        if (f) begin
            mq.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            bit was_full;
            bit was_empty;
            was_full  = (mq.size() == DEPTH);
            was_empty = (mq.size() == 0);
            if (r && !was_empty) begin
                m_rd    = mq.pop_front();
                m_valid = 1'b1;
                exp_q.push_back(m_rd);
            end else if (r) begin
                m_udf = 1'b1;
            end
            if (w && !was_full) mq.push_back(wd);
            else if (w) m_ovf = 1'b1;
        end
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        flush = 1'b0;
    endtask

    // Assert rst between edges while a write is pending; outputs must clear immediately.
    task automatic async_reset();
        wr_en   = 1'b1;
        wr_data = DW'($urandom);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_level", 32'(level), 32'(0));
        chk("rst_empty", 32'(empty), 32'(1));
        chk("rst_almost_empty", 32'(almost_empty), 32'(1));
        chk("rst_rd_data", 32'(rd_data), 32'(0));
        chk("rst_overflow", 32'(overflow), 32'(0));
        chk("rst_underflow", 32'(underflow), 32'(0));
        model_reset();
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rst   = 1'b0;
    endtask

    // Per-cycle status checker for both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("level", 32'(level), 32'(mq.size()));
            chk("empty", 32'(empty), 32'(mq.size() == 0));
            chk("full", 32'(full), 32'(mq.size() == DEPTH));
            chk("almost_empty", 32'(almost_empty), 32'(mq.size() <= AE));
            chk("almost_full", 32'(almost_full), 32'(mq.size() >= AF));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("underflow", 32'(underflow), 32'(m_udf));
            chk("rd_valid", 32'(rd_valid), 32'(m_valid));
            chk("rd_data_hold", 32'(rd_data), 32'(m_rd));
            chk("fwft_level", 32'(f_level), 32'(mq.size()));
            chk("fwft_flags", 32'({f_overflow, f_underflow}), 32'({m_ovf, m_udf}));
            chk("fwft_rd_valid", 32'(f_rd_valid), 32'(mq.size() != 0));
            if (mq.size() != 0) chk("fwft_rd_data", 32'(f_rd_data), 32'(mq[0]));
        end
    end

    // Scoreboard monitor: every rd_valid pulse consumes one expected word.
    always @(negedge clk) begin
        if (chk_en && rd_valid) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_pop", 32'(1), 32'(0));
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                $display("rd data=%02h expected=%02h level=%0d", rd_data, e, level);
                chk("sb_rd_data", 32'(rd_data), 32'(e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;

        // Reset mid-burst, then a single write becomes visible next cycle.
        for (int i = 0; i < 3; i++) step(1'b1, DW'(8'h40 + i), 1'b0, 1'b0);
        async_reset();
        step(1'b1, 8'h11, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        // Fill to full plus one rejected write, then drain plus one rejected read.
        for (int i = 1; i <= 13; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
        for (int i = 0; i < 13; i++) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);

        // Pointer wrap: four rounds of eight writes then eight reads.
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 8; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
            for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0);
        end

        // Simultaneous read+write at level 5, 0 and DEPTH.
        for (int i = 0; i < 5; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 8'h66, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
        step(1'b1, 8'h77, 1'b1, 1'b0);

        // Flush at level 7 with a concurrent write that must be discarded.
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0);

        // Random traffic with occasional flush and asynchronous reset.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                async_reset();
            end else begin
                step(($urandom_range(0, 99) < 55), DW'($urandom), ($urandom_range(0, 99) < 45),
                     ($urandom_range(0, 39) == 0));
            end
        end

        step(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        chk_en = 1'b0;
        chk("sb_leftover", 32'(exp_q.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
